// File: rtl/hpf_pkg.sv
// hpf_pkg
//   Constants and types shared by the high-pass filter and its split-sample
//   transmitter, so that frame alignment is defined in exactly one place.
//   Contents: frame length / low-nibble slot defaults, sample and nibble widths,
//   the transmitter FSM state enum and a saturating-increment helper.
package hpf_pkg;

  localparam int HPF_FRAME_LEN = 20;
  localparam int HPF_LO_SLOT   = 2;
  localparam int SAMPLE_W      = 8;
  localparam int NIBBLE_W      = 4;
  localparam int SLOT_W        = 5;
  localparam int UCNT_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_LO = 2'd1,
    ST_SEND_HI = 2'd2
  } tx_state_e;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
    if (v == {UCNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(UCNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/hpf_sample_fifo.sv
// hpf_sample_fifo
//   Synchronous FIFO holding samples waiting for their frame slot.
//   DEPTH must be a power of two (pointers wrap naturally).
//   Ports:
//     clk, reset   clock, asynchronous active-high reset (FIFO emptied)
//     i_push       write i_wdata; ignored while full
//     i_wdata      sample to store
//     i_pop        discard the head entry; ignored while empty
//     o_rdata      current head entry (valid while !o_empty)
//     o_full       registered full flag
//     o_empty      registered empty flag
module hpf_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  // A push is refused when full even if a pop happens on the same edge.
  assign w_push  = i_push && !r_full;
  assign w_pop   = i_pop && !r_empty;
  assign o_rdata = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == LP_DEPTH);
      r_empty <= (w_count_nxt == '0);
    end
  end

endmodule

// File: rtl/hpf_nibble_tx.sv
// hpf_nibble_tx
//   Transmit end of the 4-bit split-sample link into the filter's x_half input.
//   Samples arrive over valid/ready, wait in a small FIFO and are sent as low
//   nibble then high nibble in slots LO_SLOT / LO_SLOT+1 of a free-running frame.
//   An empty FIFO at the pop slot sends a zero sample and flags underrun.
//   Ports:
//     clk, reset          clock, asynchronous active-high reset
//     i_s_valid/i_s_data  offered 8-bit two's-complement sample
//     o_s_ready           FIFO not full
//     o_x_half            nibble stream, zero outside the two data slots
//     o_slot              current frame slot
//     o_sample_sent       pulse in slot LO_SLOT+1 for a real sample
//     o_underrun          pulse in slot LO_SLOT when a filler zero goes out
//     o_underrun_cnt      saturating count of filler frames
module hpf_nibble_tx
  import hpf_pkg::*;
#(
  parameter int FRAME_LEN  = HPF_FRAME_LEN,
  parameter int LO_SLOT    = HPF_LO_SLOT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_s_valid,
  input  logic [SAMPLE_W-1:0] i_s_data,
  output logic                o_s_ready,
  output logic [NIBBLE_W-1:0] o_x_half,
  output logic [SLOT_W-1:0]   o_slot,
  output logic                o_sample_sent,
  output logic                o_underrun,
  output logic [UCNT_W-1:0]   o_underrun_cnt
);

  localparam logic [SLOT_W-1:0] LP_SLOT_LAST = SLOT_W'(FRAME_LEN - 1);
  localparam logic [SLOT_W-1:0] LP_POP_SLOT  = SLOT_W'(LO_SLOT - 1);
  localparam logic [SLOT_W-1:0] LP_LO_SLOT   = SLOT_W'(LO_SLOT);

  logic [SLOT_W-1:0]   r_slot;
  tx_state_e           r_state;
  logic [NIBBLE_W-1:0] r_x_half;
  logic [NIBBLE_W-1:0] r_hold_hi;
  logic                r_real;
  logic                r_sample_sent;
  logic                r_underrun;
  logic [UCNT_W-1:0]   r_underrun_cnt;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop_edge;
  logic                w_pop;
  logic [SAMPLE_W-1:0] w_head;

  assign w_push     = i_s_valid && !w_full;
  assign w_pop_edge = (r_slot == LP_POP_SLOT);
  assign w_pop      = w_pop_edge && !w_empty;

  hpf_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (i_s_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Free-running frame slot counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot <= '0;
    end else if (r_slot == LP_SLOT_LAST) begin
      r_slot <= '0;
    end else begin
      r_slot <= r_slot + 1'b1;
    end
  end

  // FSM tracks the slot one edge ahead; outputs are loaded on the same edges.
  // The low nibble leaves straight from the FIFO head, so only the high nibble
  // (which carries the sign bit) needs holding for the following slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_x_half       <= '0;
      r_hold_hi      <= '0;
      r_real         <= 1'b0;
      r_sample_sent  <= 1'b0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      if (w_pop_edge) begin
        r_state <= ST_SEND_LO;
      end else if (r_slot == LP_LO_SLOT) begin
        r_state <= ST_SEND_HI;
      end else begin
        r_state <= ST_IDLE;
      end

      if (w_pop_edge) begin
        r_sample_sent <= 1'b0;
        if (!w_empty) begin
          r_hold_hi  <= w_head[SAMPLE_W-1:NIBBLE_W];
          r_x_half   <= w_head[NIBBLE_W-1:0];
          r_real     <= 1'b1;
          r_underrun <= 1'b0;
        end else begin
          r_hold_hi      <= '0;
          r_x_half       <= '0;
          r_real         <= 1'b0;
          r_underrun     <= 1'b1;
          r_underrun_cnt <= sat_inc(r_underrun_cnt);
        end
      end else begin
        case (r_state)
          ST_SEND_LO: begin
            r_x_half      <= r_hold_hi;
            r_underrun    <= 1'b0;
            r_sample_sent <= r_real;
          end
          ST_SEND_HI: begin
            r_x_half      <= '0;
            r_underrun    <= 1'b0;
            r_sample_sent <= 1'b0;
          end
          default: begin
            r_x_half      <= '0;
            r_underrun    <= 1'b0;
            r_sample_sent <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_s_ready      = !w_full;
  assign o_x_half       = r_x_half;
  assign o_slot         = r_slot;
  assign o_sample_sent  = r_sample_sent;
  assign o_underrun     = r_underrun;
  assign o_underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_hpf_nibble_tx.sv
module tb_hpf_nibble_tx;

  localparam int FRAME_LEN = 20;
  localparam int LO_SLOT   = 2;
  localparam int DEPTH     = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_s_valid;
  logic [7:0] i_s_data;
  logic       o_s_ready;
  logic [3:0] o_x_half;
  logic [4:0] o_slot;
  logic       o_sample_sent;
  logic       o_underrun;
  logic [7:0] o_underrun_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         skip;   // frame whose pop edge this sample arrived on, else -1
  } ent_t;

  ent_t exp_q[$];

  int model_slot;
  int model_frame;
  int model_ucnt;
  logic       cur_real;
  logic [3:0] cur_hi;

  hpf_nibble_tx dut (
    .clk            (clk),
    .reset          (reset),
    .i_s_valid      (i_s_valid),
    .i_s_data       (i_s_data),
    .o_s_ready      (o_s_ready),
    .o_x_half       (o_x_half),
    .o_slot         (o_slot),
    .o_sample_sent  (o_sample_sent),
    .o_underrun     (o_underrun),
    .o_underrun_cnt (o_underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference slot / frame counters.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_slot  <= 0;
      model_frame <= 0;
    end else if (model_slot == FRAME_LEN - 1) begin
      model_slot  <= 0;
      model_frame <= model_frame + 1;
    end else begin
      model_slot <= model_slot + 1;
    end
  end

  // Monitor: compares every cycle against the scoreboard queue.
  always @(negedge clk) begin
    ent_t e;
    if (reset) begin
      exp_q.delete();
      model_ucnt = 0;
      cur_real   = 1'b0;
      cur_hi     = 4'h0;
    end else begin
      chk("slot", int'(o_slot), model_slot);
      if (model_slot == LO_SLOT) begin
        if (exp_q.size() > 0 && exp_q[0].skip != model_frame) begin
          e = exp_q.pop_front();
          cur_real = 1'b1;
          cur_hi   = e.data[7:4];
          chk("x_half_lo", int'(o_x_half), int'(e.data[3:0]));
          chk("underrun_lo", int'(o_underrun), 0);
        end else begin
          cur_real = 1'b0;
          cur_hi   = 4'h0;
          if (model_ucnt < 255) model_ucnt++;
          chk("x_half_filler", int'(o_x_half), 0);
          chk("underrun_pulse", int'(o_underrun), 1);
        end
        chk("sent_lo", int'(o_sample_sent), 0);
      end else if (model_slot == LO_SLOT + 1) begin
        chk("x_half_hi", int'(o_x_half), int'(cur_hi));
        chk("sample_sent", int'(o_sample_sent), int'(cur_real));
        chk("underrun_hi", int'(o_underrun), 0);
      end else begin
        chk("x_half_idle", int'(o_x_half), 0);
        chk("sent_idle", int'(o_sample_sent), 0);
        chk("underrun_idle", int'(o_underrun), 0);
      end
      chk("underrun_cnt", int'(o_underrun_cnt), model_ucnt);
      chk("s_ready", int'(o_s_ready), (exp_q.size() < DEPTH) ? 1 : 0);
    end
  end

  // Hold valid until the bench's own occupancy count says the FIFO accepts.
  task automatic push(input logic [7:0] d);
    bit   done = 1'b0;
    int   n = 0;
    ent_t e;
    i_s_valid = 1'b1;
    i_s_data  = d;
    while (!done && n < 100) begin
      @(posedge clk);
      if (exp_q.size() < DEPTH) begin
        e.data = d;
        e.skip = (model_slot == LO_SLOT - 1) ? model_frame : -1;
        exp_q.push_back(e);
        done = 1'b1;
      end
      n++;
    end
    chk("push_accept_timeout", int'(done), 1);
    @(negedge clk);
    i_s_valid = 1'b0;
  endtask

  task automatic wait_fs(input int f, input int s);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(model_frame == f && model_slot == s) && n < 8000);
    chk("wait_timeout", (model_frame == f && model_slot == s) ? 1 : 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    i_s_valid = 1'b0;
    i_s_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_slot", int'(o_slot), 0);
    chk("rst_x_half", int'(o_x_half), 0);
    chk("rst_ready", int'(o_s_ready), 1);
    chk("rst_sent", int'(o_sample_sent), 0);
    chk("rst_underrun", int'(o_underrun), 0);
    chk("rst_ucnt", int'(o_underrun_cnt), 0);
    #1 reset = 1'b0;

    // Alignment: 0xA5 offered in slot 0 goes out in frame 0.
    push(8'hA5);

    // Burst: fills the FIFO, drains one per frame (frames 1..4).
    wait_fs(0, 5);
    push(8'h01);
    push(8'h7F);
    push(8'h80);
    push(8'hFF);

    // Underrun: frames 5..7 carry filler.
    wait_fs(7, 3);
    chk("ucnt_after_3_idle", int'(o_underrun_cnt), 3);

    // Full FIFO with valid held across the pop edge.
    wait_fs(8, 5);
    push(8'h5A);
    push(8'hC3);
    push(8'h96);
    push(8'h0F);
    wait_fs(8, 15);
    push(8'hE1);

    // Reset while 0x3C is on the wire with two samples behind it.
    wait_fs(14, 5);
    push(8'h3C);
    push(8'h11);
    push(8'h22);
    wait_fs(15, 2);
    #1 reset = 1'b1;
    #1;
    chk("midrst_x_half", int'(o_x_half), 0);
    chk("midrst_slot", int'(o_slot), 0);
    chk("midrst_ready", int'(o_s_ready), 1);
    chk("midrst_ucnt", int'(o_underrun_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    wait_fs(0, 3);
    chk("post_rst_ucnt", int'(o_underrun_cnt), 1);

    // Saturation after 300 idle frames.
    wait_fs(300, 3);
    chk("ucnt_saturated", int'(o_underrun_cnt), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
